// File: rtl/johnson_decoder.sv
// Johnson code word decoder with sequence tracking.
// Each accepted sample is decoded to a state index and checked for legality.
// A lock/unlock FSM follows the expected successor sequence, and a saturating
// counter records illegal words and sequence breaks.
module johnson_decoder #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int MISS_MAX = 2,
    parameter int IW       = $clog2(2*N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [N-1:0]  jc_in,
    output logic          out_valid,
    output logic [IW-1:0] index,
    output logic          illegal,
    output logic          seq_err,
    output logic          locked,
    output logic [7:0]    err_count
);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} fsm_t;

    // Code word for state k: k low ones for k <= N, otherwise ones above
    // the low (k-N) zero bits.
    function automatic logic [N-1:0] code_of(input int k);
        logic [N-1:0] w;
        w = '0;
        for (int b = 0; b < N; b++) begin
            if (k <= N) w[b] = (b < k);
            else        w[b] = (b >= k - N);
        end
        return w;
    endfunction

    fsm_t          fsm_q, fsm_d;
    logic [3:0]    run_q, run_d;
    logic [3:0]    miss_q, miss_d;
    logic [IW-1:0] exp_q, exp_d;
    logic [IW-1:0] index_q, index_d;
    logic          out_valid_q, out_valid_d;
    logic          illegal_q, illegal_d;
    logic          seq_err_q, seq_err_d;
    logic [7:0]    err_count_q, err_count_d;

    logic          dec_legal;
    logic [IW-1:0] dec_idx;
    logic [IW-1:0] dec_succ;
    logic [3:0]    run_next;
    logic [3:0]    miss_next;
    logic          err_event;

    // Match the input word against every legal code word.
    always_comb begin
        dec_legal = 1'b0;
        dec_idx   = '0;
        for (int k = 0; k < 2*N; k++) begin
            if (jc_in == code_of(k)) begin
                dec_legal = 1'b1;
                dec_idx   = IW'(k);
            end
        end
        if (dec_idx == IW'(2*N - 1)) dec_succ = '0;
        else                         dec_succ = dec_idx + IW'(1);
    end

    // Next-state logic for the lock FSM, sequence tracking and error counting.
    always_comb begin
        fsm_d       = fsm_q;
        run_d       = run_q;
        miss_d      = miss_q;
        exp_d       = exp_q;
        index_d     = index_q;
        out_valid_d = in_valid;
        illegal_d   = 1'b0;
        seq_err_d   = 1'b0;
        err_count_d = err_count_q;
        err_event   = 1'b0;
        run_next    = '0;
        miss_next   = '0;

        if (in_valid) begin
            if (!dec_legal) begin
                illegal_d = 1'b1;
                err_event = 1'b1;
                fsm_d     = UNLOCKED;
                run_d     = '0;
            end else begin
                index_d = dec_idx;
                exp_d   = dec_succ;
                if (fsm_q == UNLOCKED) begin
                    if (dec_idx == exp_q && run_q != '0) run_next = run_q + 4'd1;
                    else                                 run_next = 4'd1;
                    run_d = run_next;
                    if (run_next >= 4'(LOCK_CNT)) begin
                        fsm_d  = LOCKED;
                        miss_d = '0;
                    end
                end else begin
                    if (dec_idx == exp_q) begin
                        miss_d = '0;
                    end else begin
                        seq_err_d = 1'b1;
                        err_event = 1'b1;
                        miss_next = miss_q + 4'd1;
                        miss_d    = miss_next;
                        if (miss_next >= 4'(MISS_MAX)) begin
                            fsm_d = UNLOCKED;
                            run_d = 4'd1;
                        end
                    end
                end
            end
        end

        if (err_event && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= UNLOCKED;
            run_q       <= '0;
            miss_q      <= '0;
            exp_q       <= '0;
            index_q     <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            exp_q       <= exp_d;
            index_q     <= index_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign index     = index_q;
    assign illegal   = illegal_q;
    assign seq_err   = seq_err_q;
    assign locked    = (fsm_q == LOCKED);
    assign err_count = err_count_q;

endmodule
